// File: rtl/spi_loader_pkg.sv
// Shared opcodes, FSM states and command decode for spi_matrix_loader.
// SPI_READBACK_EN enables the READ and STATUS opcodes.
package spi_loader_pkg;

   localparam logic [7:0] CMD_WR_BASE = 8'h10;
   localparam logic [7:0] CMD_RD_BASE = 8'h20;
   localparam logic [7:0] CMD_STATUS  = 8'h30;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WRITE,
      READ,
      STATUS,
      DISCARD
   } state_t;

   // Map the first byte of a frame to the state that handles the rest.
   function automatic state_t decode_cmd(
      input logic [7:0]  op,
      input int unsigned nm
   );
      logic   m_ok;
      state_t s;
      m_ok = 32'(op[3:0]) < nm;
      s    = DISCARD;
      if (op[7:4] == CMD_WR_BASE[7:4] && m_ok)
         s = WRITE;
`ifdef SPI_READBACK_EN
      if (op[7:4] == CMD_RD_BASE[7:4] && m_ok)
         s = READ;
      if (op == CMD_STATUS)
         s = STATUS;
`else
      if (op[7:4] == CMD_RD_BASE[7:4] || op == CMD_STATUS)
         s = DISCARD;
`endif
      return s;
   endfunction

endpackage

// File: rtl/spi_matrix_loader_if.sv
// SPI pin bundle between an SPI master and spi_matrix_loader.
// SPI_READBACK_EN decides whether the slave actually drives miso.
interface spi_matrix_loader_if;

   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;

   modport master (
      output sclk,
      output cs_n,
      output mosi,
      input  miso
   );

   modport slave (
      input  sclk,
      input  cs_n,
      input  mosi,
      output miso
   );

endinterface

// File: rtl/spi_byte_shifter.sv
// Oversampled SPI mode-0 byte shifter: sync, edge detect, rx/tx bytes.
// SPI_READBACK_EN adds the tx shifter; otherwise miso is tied low.
module spi_byte_shifter (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_matrix_loader_if.slave   spi,
`ifdef SPI_READBACK_EN
   input  logic                 tx_load,
   input  logic [7:0]           tx_data,
`endif
   output logic                 byte_valid,
   output logic [7:0]           rx_byte,
   output logic                 frame_start,
   output logic                 frame_end
);

   logic       sclk_m, sclk_s, sclk_d;
   logic       cs_m, cs_s, cs_d;
   logic       mosi_m, mosi_s;
   logic       rise;
   logic [2:0] bit_cnt;
   logic [6:0] rx_sr;

   // Two-flop synchronisers plus one delay stage for edge detection.
   // cs resets to "selected" so a frame in flight at reset release
   // produces no frame_start and is ignored until cs_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_m <= 1'b0;
         sclk_s <= 1'b0;
         sclk_d <= 1'b0;
         cs_m   <= 1'b0;
         cs_s   <= 1'b0;
         cs_d   <= 1'b0;
         mosi_m <= 1'b0;
         mosi_s <= 1'b0;
      end else begin
         sclk_m <= spi.sclk;
         sclk_s <= sclk_m;
         sclk_d <= sclk_s;
         cs_m   <= spi.cs_n;
         cs_s   <= cs_m;
         cs_d   <= cs_s;
         mosi_m <= spi.mosi;
         mosi_s <= mosi_m;
      end
   end

   assign rise        = sclk_s & ~sclk_d & ~cs_s;
   assign frame_start = cs_d & ~cs_s;
   assign frame_end   = ~cs_d & cs_s;

   // Receive shifter: MSB first, byte_valid one clk after bit 0 arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= 3'd0;
         rx_sr      <= 7'd0;
         rx_byte    <= 8'd0;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (frame_start || frame_end) begin
            bit_cnt <= 3'd0;
         end else if (rise) begin
            rx_sr   <= {rx_sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               rx_byte    <= {rx_sr, mosi_s};
            end
         end
      end
   end

`ifdef SPI_READBACK_EN
   logic       fall;
   logic [7:0] tx_sr;

   assign fall = ~sclk_s & sclk_d & ~cs_s;

   // Transmit shifter: the fall after bit 0 does not shift, so a byte
   // loaded during that high phase keeps its MSB on miso.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tx_sr <= 8'd0;
      else if (frame_end)
         tx_sr <= 8'd0;
      else if (tx_load)
         tx_sr <= tx_data;
      else if (fall && bit_cnt != 3'd0)
         tx_sr <= {tx_sr[6:0], 1'b0};
   end

   assign spi.miso = ~spi.cs_n & tx_sr[7];
`else
   assign spi.miso = 1'b0;
`endif

endmodule

// File: rtl/spi_matrix_loader.sv
// SPI-slave matrix loader: command FSM, element storage, core read port.
// SPI_READBACK_EN adds READ/STATUS commands and the overflow flag readout.
module spi_matrix_loader
   import spi_loader_pkg::*;
#(
   parameter  int DATA_W  = 16,
   parameter  int DEPTH   = 16,
   parameter  int NUM_MAT = 2,
   localparam int MW      = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   spi_matrix_loader_if.slave  spi,
   output logic                irq,
   input  logic [MW-1:0]       rd_mat,
   input  logic [AW-1:0]       rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic [NUM_MAT-1:0]  load_done
);

   localparam int NB = DATA_W / 8;
   localparam int LW = (NB > 1) ? $clog2(NB) : 1;

   state_t              state, state_n, cmd_state;
   logic                byte_valid, frame_start, frame_end;
   logic [7:0]          rx_byte;
   logic [MW-1:0]       cur_mat, m_dec;
   logic [AW-1:0]       elem, elem_nx;
   logic [LW-1:0]       lane, lane_nx;
   logic                last_lane, last_elem, full;
   logic                cmd_fire, wr_cmd, wr_fire, adv, done_fire;
   logic                irq_clr;
   logic [DATA_W-1:0]   mem [NUM_MAT][DEPTH];

`ifdef SPI_READBACK_EN
   logic                tx_load;
   logic [7:0]          tx_data;
   logic                overflow, ovf_fire, st_done;
`endif

   spi_byte_shifter u_shift (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi         (spi),
`ifdef SPI_READBACK_EN
      .tx_load     (tx_load),
      .tx_data     (tx_data),
`endif
      .byte_valid  (byte_valid),
      .rx_byte     (rx_byte),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

   assign cmd_state = decode_cmd(rx_byte, NUM_MAT);
   assign m_dec     = rx_byte[MW-1:0];
   assign cmd_fire  = (state == CMD) && byte_valid;
   assign wr_cmd    = cmd_fire && (cmd_state == WRITE);
   assign wr_fire   = (state == WRITE) && byte_valid && !full;
   assign adv       = wr_fire || ((state == READ) && byte_valid);

   assign last_lane = (lane == LW'(NB - 1));
   assign last_elem = (elem == AW'(DEPTH - 1));
   assign lane_nx   = last_lane ? '0 : lane + 1'b1;
   assign elem_nx   = !last_lane ? elem :
                      (last_elem ? '0 : elem + 1'b1);
   assign done_fire = wr_fire && last_lane && last_elem;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next state: a cs_n rise always returns to IDLE.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (frame_start) state_n = CMD;
         CMD:     if (byte_valid)  state_n = cmd_state;
         STATUS:  if (byte_valid)  state_n = DISCARD;
         default: state_n = state;
      endcase
      if (frame_end)
         state_n = IDLE;
   end

   // Byte/element pointer shared by WRITE and READ; full marks the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem    <= '0;
         lane    <= '0;
         full    <= 1'b0;
         cur_mat <= '0;
      end else if (frame_end) begin
         elem    <= '0;
         lane    <= '0;
         full    <= 1'b0;
      end else if (cmd_fire) begin
         elem    <= '0;
         lane    <= '0;
         full    <= 1'b0;
         cur_mat <= m_dec;
      end else if (adv) begin
         lane    <= lane_nx;
         elem    <= elem_nx;
         if (done_fire)
            full <= 1'b1;
      end
   end

   // Element storage, written one byte lane at a time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < NUM_MAT; m++)
            for (int i = 0; i < DEPTH; i++)
               mem[m][i] <= '0;
      end else if (wr_fire) begin
         mem[cur_mat][elem][8*int'(lane) +: 8] <= rx_byte;
      end
   end

   // Registered core read port; a same-edge SPI write is not forwarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else
         rd_data <= mem[rd_mat][rd_addr];
   end

   // Per-matrix completion flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_done <= '0;
      end else begin
         if (wr_cmd)
            load_done[m_dec] <= 1'b0;
         if (done_fire)
            load_done[cur_mat] <= 1'b1;
      end
   end

`ifdef SPI_READBACK_EN
   assign st_done  = (state == STATUS) && byte_valid;
   assign ovf_fire = (state == WRITE) && byte_valid && full;
   assign irq_clr  = st_done;

   // Overflow flag: extra bytes after a full matrix; cleared by STATUS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (ovf_fire)
         overflow <= 1'b1;
      else if (st_done)
         overflow <= 1'b0;
   end

   // Next byte for miso: first one at CMD decode, then one per byte.
   always_comb begin
      tx_load = 1'b0;
      tx_data = 8'd0;
      if (cmd_fire) begin
         tx_load = 1'b1;
         if (cmd_state == READ)
            tx_data = mem[m_dec][0][7:0];
         else if (cmd_state == STATUS)
            tx_data = {overflow, 3'b000, 4'(load_done)};
      end else if ((state == READ) && byte_valid) begin
         tx_load = 1'b1;
         tx_data = mem[cur_mat][elem_nx][8*int'(lane_nx) +: 8];
      end else if (st_done) begin
         tx_load = 1'b1;
      end
   end
`else
   assign irq_clr = wr_cmd;
`endif

   // Completion interrupt; a set on the same edge as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         irq <= 1'b0;
      else if (done_fire)
         irq <= 1'b1;
      else if (irq_clr)
         irq <= 1'b0;
   end

endmodule

// File: tb/tb_spi_matrix_loader.sv
// Directed + random frames against a byte-level model of the loader.
// Readback checks are active when SPI_READBACK_EN is defined.
module tb_spi_matrix_loader;

   localparam int NB    = 2;
   localparam int DEPTH = 16;
   localparam int NM    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:0]  rd_mat;
   logic [3:0]  rd_addr;
   logic [15:0] rd_data;
   logic        irq;
   logic [1:0]  load_done;

   int n_chk = 0;
   int n_fail = 0;

   logic [15:0] em [NM][DEPTH];
   logic [1:0]  edone;
   logic        eirq, eovf;
   int          fk;
   logic [7:0]  fcmd;
   bit          f_dead;

   spi_matrix_loader_if spi_bus ();

   spi_matrix_loader #(
      .DATA_W  (16),
      .DEPTH   (DEPTH),
      .NUM_MAT (NM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi       (spi_bus),
      .irq       (irq),
      .rd_mat    (rd_mat),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .load_done (load_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_wr(input logic [7:0] b);
      return b[7:4] == 4'h1 && int'(b[3:0]) < NM;
   endfunction

   function automatic bit is_rd(input logic [7:0] b);
      return b[7:4] == 4'h2 && int'(b[3:0]) < NM;
   endfunction

   task automatic mdl_reset();
      for (int m = 0; m < NM; m++)
         for (int i = 0; i < DEPTH; i++)
            em[m][i] = 16'h0;
      edone = 2'b00;
      eirq  = 1'b0;
      eovf  = 1'b0;
   endtask

   // Model one complete byte of the current frame; mexp is the miso byte.
   task automatic mdl_byte(input logic [7:0] b, output logic [7:0] mexp);
      int j, m, e, l;
      mexp = 8'h00;
      if (!f_dead) begin
         if (fk == 0) begin
            fcmd = b;
            if (is_wr(b)) begin
               edone[b[0]] = 1'b0;
`ifndef SPI_READBACK_EN
               eirq = 1'b0;
               eovf = 1'b0;
`endif
            end
         end else begin
            j = fk - 1;
            m = int'(fcmd[3:0]);
            e = j / NB;
            l = j % NB;
            if (is_wr(fcmd)) begin
               if (j < NB * DEPTH) begin
                  em[m][e][8*l +: 8] = b;
                  if (j == NB * DEPTH - 1) begin
                     edone[m] = 1'b1;
                     eirq     = 1'b1;
                  end
               end else begin
                  eovf = 1'b1;
               end
            end
`ifdef SPI_READBACK_EN
            else if (is_rd(fcmd)) begin
               mexp = em[m][e % DEPTH][8*l +: 8];
            end else if (fcmd == 8'h30 && j == 0) begin
               mexp = {eovf, 3'b000, 2'b00, edone};
               eirq = 1'b0;
               eovf = 1'b0;
            end
`endif
         end
      end
      fk++;
   endtask

   task automatic xfer(input logic [7:0] b, input int nbits,
                       output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_bus.mosi = b[i];
         repeat (6) @(negedge clk);
         r[i] = spi_bus.miso;
         spi_bus.sclk = 1'b1;
         repeat (6) @(negedge clk);
         spi_bus.sclk = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic [7:0] r, mexp;
      xfer(b, 8, r);
      mdl_byte(b, mexp);
      chk("miso", 32'(r), 32'(mexp));
      chk("irq", 32'(irq), 32'(eirq));
      chk("load_done", 32'(load_done), 32'(edone));
   endtask

   task automatic frame_open();
      @(negedge clk);
      spi_bus.cs_n = 1'b0;
      fk     = 0;
      f_dead = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic frame_close();
      repeat (4) @(negedge clk);
      spi_bus.cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic check_mem();
      for (int m = 0; m < NM; m++) begin
         for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            rd_mat  = 1'(m);
            rd_addr = 4'(i);
            @(negedge clk);
            chk($sformatf("mem[%0d][%0d]", m, i), 32'(rd_data),
                32'(em[m][i]));
         end
      end
   endtask

   task automatic rand_write(input logic [7:0] cmd);
      frame_open();
      send(cmd);
      for (int i = 0; i < NB * DEPTH; i++)
         send(8'($urandom_range(0, 255)));
      frame_close();
      check_mem();
   endtask

   initial begin
      logic [7:0] junk;
      spi_bus.cs_n = 1'b1;
      spi_bus.sclk = 1'b0;
      spi_bus.mosi = 1'b0;
      rd_mat  = 1'b0;
      rd_addr = 4'd0;
      mdl_reset();
      fk     = 0;
      fcmd   = 8'h00;
      f_dead = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_miso", 32'(spi_bus.miso), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_load_done", 32'(load_done), 32'h0);
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Full write of matrix 0 with element i = 0x0100 + i.
      frame_open();
      send(8'h10);
      for (int i = 0; i < DEPTH; i++) begin
         send(8'(i));
         send(8'h01);
      end
      frame_close();
      check_mem();

      // Readback of matrix 0 (four bytes: 00 01 01 01).
      frame_open();
      send(8'h20);
      for (int i = 0; i < 4; i++)
         send(8'($urandom_range(0, 255)));
      frame_close();

      // Aborted frame with a trailing half byte, then a short rewrite.
      frame_open();
      send(8'h10);
      send(8'hAA);
      send(8'hBB);
      send(8'hCC);
      xfer(8'hF0, 4, junk);
      frame_close();
      frame_open();
      send(8'h10);
      send(8'h05);
      send(8'h00);
      frame_close();
      check_mem();

      // Matrix 1 with random data and two overflow bytes.
      frame_open();
      send(8'h11);
      for (int i = 0; i < NB * DEPTH; i++)
         send(8'($urandom_range(0, 255)));
      send(8'hFF);
      send(8'hFF);
      frame_close();
      check_mem();

      // Status read (0x82 with readback), then irq is low.
      frame_open();
      send(8'h30);
      send(8'h00);
      frame_close();

      // Invalid and (without readback) disabled opcodes.
      frame_open();
      send(8'h12);
      for (int i = 0; i < 4; i++)
         send(8'($urandom_range(0, 255)));
      frame_close();
      frame_open();
      send(8'h7F);
      for (int i = 0; i < 4; i++)
         send(8'($urandom_range(0, 255)));
      frame_close();
      frame_open();
      send(8'h21);
      for (int i = 0; i < 4; i++)
         send(8'($urandom_range(0, 255)));
      frame_close();
      frame_open();
      send(8'h30);
      send(8'($urandom_range(0, 255)));
      send(8'($urandom_range(0, 255)));
      frame_close();
      check_mem();

      // Random full write of matrix 0.
      rand_write(8'h10);

      // Reset in the middle of a write frame.
      frame_open();
      send(8'h11);
      for (int i = 0; i < 5; i++)
         send(8'($urandom_range(0, 255)));
      @(negedge clk);
      rst_n = 1'b0;
      mdl_reset();
      f_dead = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_irq", 32'(irq), 32'h0);
      chk("midrst_load_done", 32'(load_done), 32'h0);
      chk("midrst_rd_data", 32'(rd_data), 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++)
         send(8'($urandom_range(0, 255)));
      frame_close();
      check_mem();

      // Recovery after reset.
      rand_write(8'h11);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_matrix_loader.md
# spi_matrix_loader

Parametrised SPI-slave front end for the systolic array: receives framed commands over SPI (mode 0), writes multi-byte matrix elements into per-matrix storage, and exposes a registered read port to the compute core. It generalises the single-matrix, 16-bit, per-byte-chip-select loader to configurable element width, depth and matrix count, with synchronous oversampling of the SPI pins, overflow detection, a status byte and a completion interrupt.

## Interface
- DATA_W, 16, element width in bits; multiple of 8, from 8 to 32
- DEPTH, 16, elements per matrix; power of 2
- NUM_MAT, 2, number of matrices; 1 to 4
- clk input 1 system clock; everything, including SPI sampling, runs on it
- rst_n input 1 asynchronous active-low reset
- sclk input 1 SPI clock, asynchronous to clk
- cs_n input 1 SPI chip select, active low, asynchronous
- mosi input 1 SPI data in, asynchronous
- miso output 1 SPI data out; 0 whenever cs_n is high
- irq output 1 level interrupt: some matrix completed loading since the last status read
- rd_mat input $clog2(NUM_MAT) matrix select for the core read port
- rd_addr input $clog2(DEPTH) element index for the core read port
- rd_data output DATA_W registered read data
- load_done output NUM_MAT per-matrix "fully loaded" flags

## Operation
- sclk, cs_n and mosi each pass through a 2-FF synchroniser. An sclk rise samples mosi; an sclk fall shifts miso. Bits are MSB first.
- A frame is one cs_n-low interval. A cs_n rise returns the block to IDLE and clears the bit, byte and element counters. A partially assembled byte is discarded.
- States:
  - IDLE: cs_n falls -> CMD.
  - CMD: the first byte is decoded:
    - 0x10+m -> WRITE(m); clears load_done[m].
    - 0x20+m -> READ(m).
    - 0x30 -> STATUS.
    - Any other value, or m ≥ NUM_MAT -> DISCARD.
  - WRITE: elements are little-endian, DATA_W/8 bytes each, and each byte goes directly into its byte lane. After the last byte of element DEPTH-1, load_done[m] and irq are set. Any further bytes in the same frame set the overflow flag and are dropped.
  - READ: miso streams elements 0..DEPTH-1 in the same little-endian byte order. The element index wraps to 0 after DEPTH-1.
  - STATUS: miso returns {overflow, 3'b0, load_done zero-extended to 4 bits}. On completion of that byte, irq and overflow clear.
  - DISCARD: ignores all traffic until cs_n rises.
- Storage is NUM_MAT×DEPTH×DATA_W registers and resets to 0.
- Core read port: rd_data is registered from storage[rd_mat][rd_addr].

## Timing
- Reset values: miso 0, irq 0, rd_data 0, load_done 0, overflow 0, storage 0, state IDLE.
- Pin-to-internal latency is 2 clk cycles. The sclk high and low phases must each last at least 4 clk cycles.
- A received byte is valid 1 clk after the synchronised sclk rise that carried its bit 0. The storage write or state change happens on the following clk edge.
- load_done[m] and irq rise on the same clk edge as the final byte write.
- rd_data latency is 1 clk. If the core reads the same element SPI writes on that edge, rd_data returns the old value.
- If an irq set and a status-read clear fall on the same edge, the set wins.
- Read data for the first byte is loaded into the output shifter when CMD is decoded. Its MSB is on miso before the first sclk rise of the next byte.
- Asserting rst_n mid-frame aborts immediately. A frame still in progress when reset releases is treated as DISCARD until cs_n rises.

## Configuration
- SPI_READBACK_EN defined: READ and STATUS commands and the miso shifter are compiled in.
- SPI_READBACK_EN undefined:
  - miso is tied to 0.
  - Opcodes 0x20+m and 0x30 go to DISCARD.
  - irq and overflow clear only on reset or on a WRITE command to any matrix.

## Structure
- Package spi_loader_pkg: opcode constants (CMD_WR_BASE=0x10, CMD_RD_BASE=0x20, CMD_STATUS=0x30) and the state enum {IDLE, CMD, WRITE, READ, STATUS, DISCARD}.
- Sub-module spi_byte_shifter contains:
  - the synchronisers and edge detect;
  - the rx shift register with a byte_valid pulse;
  - the tx shift register with a load strobe;
  - frame_start and frame_end pulses.
- The top level holds the FSM, counters, storage and read port.

## Test plan
- Write with defaults: frame 0x10 followed by 32 bytes giving element i = 0x0100+i. Required response:
  - storage[0][i] == 0x0100+i;
  - load_done == 2'b01;
  - irq goes to 1 on the final byte.
- Overflow: frame 0x11 with 34 data bytes (2 extra, value 0xFF). Required response:
  - matrix 1 is intact;
  - a following status read returns 0x82 (overflow set, load_done[1] set) and then irq is 0.
- Aborted frame: 0x10 then 3 bytes, cs_n rises, then a new frame 0x10 with 0x05,0x00. Required response: element 0 == 0x0005 and load_done[0] == 0.
- Readback: after the first test, frame 0x20 plus 4 dummy bytes. miso returns 0x00,0x01,0x01,0x01.
- Invalid commands: opcode 0x12 (with NUM_MAT=2) and opcode 0x7F, each followed by data. Required response: storage unchanged and miso stays 0.
- Reset mid-WRITE after 5 bytes. Required response:
  - all storage, load_done and irq are 0;
  - the remaining bytes of that frame are ignored.
